// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-write message path: FSM encoding,
// command byte layout and error flag positions.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CMD_DATA = 2'd1,
        ST_DISCARD  = 2'd2
    } state_e;

    localparam int CMD_WR_BIT   = 7;
    localparam int ADDR_W       = 7;
    localparam int IDX_W        = 2;   // up to four data bytes per message

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_TIMEOUT  = 1;
    localparam int ERR_OVERRUN  = 2;

endpackage

// File: rtl/spi_frame_edge.sv
// Detects the end of an SPI slave-select frame and emits a one-cycle byte
// strobe one cycle after the registered rising edge of slave select.
module spi_frame_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ss,
    output logic o_strobe
);

    logic ss_d1_q, ss_d1_d;
    logic ss_d2_q, ss_d2_d;
    logic strobe_q, strobe_d;

    always_comb begin
        ss_d1_d  = i_ss;
        ss_d2_d  = ss_d1_q;
        strobe_d = ss_d1_q & ~ss_d2_q;
    end

    // History resets high so a frame-inactive slave select never looks like a rise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ss_d1_q  <= 1'b1;
            ss_d2_q  <= 1'b1;
            strobe_q <= 1'b0;
        end else begin
            ss_d1_q  <= ss_d1_d;
            ss_d2_q  <= ss_d2_d;
            strobe_q <= strobe_d;
        end
    end

    assign o_strobe = strobe_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Assembles SPI bytes into command + data register-write messages and issues
// them to the register bank over a valid/ready handshake, flagging errors.
module spi_reg_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 65535,
    parameter int CNT_W       = 16
) (
    input  logic              i_sys_clk,
    input  logic              i_rst_n,
    input  logic              i_spi_ss,
    input  logic [7:0]        i_data,
    input  logic              i_data_load,
    input  logic              i_err_clr,
    output logic [6:0]        o_reg_addr,
    output logic [DATA_W-1:0] o_reg_data,
    output logic              o_reg_wr_valid,
    input  logic              i_reg_wr_ready,
    output logic              o_busy,
    output logic [2:0]        o_err
);

    localparam int NBYTES = DATA_W / 8;

    // Handshake: a write is offered while o_reg_wr_valid is high with address and
    // data held stable; it completes on the first cycle i_reg_wr_ready is also high.

    logic strobe;

    spi_frame_edge u_frame_edge (
        .i_clk    (i_sys_clk),
        .i_rst_n  (i_rst_n),
        .i_ss     (i_spi_ss),
        .o_strobe (strobe)
    );

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]    tmo_q, tmo_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                wr_valid_q, wr_valid_d;
    logic [2:0]          err_q, err_d;

    logic                accept_byte;
    logic                misalign;
    logic                last_byte;
    logic                timeout_hit;
    logic                issue;
    logic                wr_accept;
    logic [DATA_W-1:0]   shift_next;

    always_comb begin
        accept_byte = strobe & i_data_load;
        misalign    = strobe & ~i_data_load;
        last_byte   = (idx_q == IDX_W'(NBYTES - 1));
        shift_next  = (shift_q << 8) | DATA_W'(i_data);
        // A byte strobe in the same cycle takes priority over the timeout.
        timeout_hit = (state_q != ST_IDLE) && (tmo_q == CNT_W'(TIMEOUT_CYC)) && !strobe;
        wr_accept   = wr_valid_q & i_reg_wr_ready;
    end

    // State register
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            addr_q     <= '0;
            shift_q    <= '0;
            tmo_q      <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_valid_q <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            shift_q    <= shift_d;
            tmo_q      <= tmo_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_valid_q <= wr_valid_d;
            err_q      <= err_d;
        end
    end

    // Next-state: message sequencing
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        issue   = 1'b0;
        if (misalign) begin
            state_d = ST_IDLE;
        end else if (accept_byte) begin
            case (state_q)
                ST_IDLE: begin
                    idx_d   = '0;
                    shift_d = '0;
                    if (i_data[CMD_WR_BIT]) begin
                        addr_d  = i_data[ADDR_W-1:0];
                        state_d = ST_CMD_DATA;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
                ST_CMD_DATA: begin
                    shift_d = shift_next;
                    idx_d   = idx_q + IDX_W'(1);
                    if (last_byte) begin
                        state_d = ST_IDLE;
                        issue   = 1'b1;
                    end
                end
                ST_DISCARD: begin
                    idx_d = idx_q + IDX_W'(1);
                    if (last_byte) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (timeout_hit) begin
            state_d = ST_IDLE;
        end
    end

    // Next-state: inter-byte timeout, write register and sticky errors
    always_comb begin
        if ((state_q == ST_IDLE) || accept_byte) begin
            tmo_d = '0;
        end else if (tmo_q != {CNT_W{1'b1}}) begin
            tmo_d = tmo_q + CNT_W'(1);
        end else begin
            tmo_d = tmo_q;
        end

        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_valid_d = wr_valid_q;
        err_d      = i_err_clr ? 3'b000 : err_q;

        // Accepting the old write frees the slot for a same-cycle issue.
        if (issue && (!wr_valid_q || wr_accept)) begin
            wr_addr_d  = addr_q;
            wr_data_d  = shift_next;
            wr_valid_d = 1'b1;
        end else begin
            if (wr_accept) begin
                wr_valid_d = 1'b0;
            end
            if (issue) begin
                err_d[ERR_OVERRUN] = 1'b1;
            end
        end
        if (misalign) begin
            err_d[ERR_MISALIGN] = 1'b1;
        end
        if (timeout_hit) begin
            err_d[ERR_TIMEOUT] = 1'b1;
        end
    end

    // Outputs
    always_comb begin
        o_busy         = (state_q != ST_IDLE) | wr_valid_q;
        o_reg_addr     = wr_addr_q;
        o_reg_data     = wr_data_q;
        o_reg_wr_valid = wr_valid_q;
        o_err          = err_q;
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: a message-level model predicts the writes
// and error flags, and a per-cycle monitor checks every offered write.
module tb_spi_reg_ctrl;

  localparam int DATA_W = 16;
  localparam int TMO    = 20;
  localparam int NB     = DATA_W / 8;
  localparam int PW     = 7 + DATA_W;

  logic              i_sys_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_spi_ss = 1'b1;
  logic [7:0]        i_data = 8'h00;
  logic              i_data_load = 1'b0;
  logic              i_err_clr = 1'b0;
  logic              i_reg_wr_ready = 1'b1;
  logic [6:0]        o_reg_addr;
  logic [DATA_W-1:0] o_reg_data;
  logic              o_reg_wr_valid;
  logic              o_busy;
  logic [2:0]        o_err;

  int checks = 0;
  int errors = 0;
  int n_accept = 0;
  int n0 = 0;

  logic [PW-1:0] exp_q[$];

  // Message-level model: 0 = waiting for command, 1 = collecting write data, 2 = skipping read
  int          m_phase = 0;
  int          m_cnt = 0;
  logic [6:0]  m_addr = 7'h00;
  logic [31:0] m_data = 32'h0;
  logic [2:0]  m_err = 3'b000;

  spi_reg_ctrl #(
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TMO),
    .CNT_W       (16)
  ) dut (
    .i_sys_clk      (i_sys_clk),
    .i_rst_n        (i_rst_n),
    .i_spi_ss       (i_spi_ss),
    .i_data         (i_data),
    .i_data_load    (i_data_load),
    .i_err_clr      (i_err_clr),
    .o_reg_addr     (o_reg_addr),
    .o_reg_data     (o_reg_data),
    .o_reg_wr_valid (o_reg_wr_valid),
    .i_reg_wr_ready (i_reg_wr_ready),
    .o_busy         (o_busy),
    .o_err          (o_err)
  );

  // Clock and watchdog
  always #5 i_sys_clk = ~i_sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of run, required finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_sys_clk);
    #1;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ld);
    if (!ld) begin
      m_err[0] = 1'b1;
      m_phase = 0;
    end else if (m_phase == 0) begin
      m_cnt = 0;
      m_data = 32'h0;
      if (b[7]) begin
        m_addr = b[6:0];
        m_phase = 1;
      end else begin
        m_phase = 2;
      end
    end else begin
      m_cnt++;
      if (m_phase == 1) m_data = (m_data << 8) | {24'h0, b};
      if (m_cnt == NB) begin
        if (m_phase == 1) begin
          if (exp_q.size() == 0) exp_q.push_back({m_addr, m_data[DATA_W-1:0]});
          else m_err[2] = 1'b1;
        end
        m_phase = 0;
      end
    end
  endtask

  // One slave-select frame carrying one byte
  task automatic send_byte(input logic [7:0] b, input bit ld = 1'b1);
    i_spi_ss = 1'b0;
    repeat (3) step();
    i_data = b;
    i_data_load = ld;
    i_spi_ss = 1'b1;
    model_byte(b, ld);
    repeat (4) step();
  endtask

  task automatic send_msg(input logic [7:0] c, input logic [7:0] d1, input logic [7:0] d0);
    send_byte(c);
    send_byte(d1);
    send_byte(d0);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
    if (n >= TMO + 5 && m_phase != 0) begin
      m_err[1] = 1'b1;
      m_phase = 0;
    end
  endtask

  task automatic err_clr();
    i_err_clr = 1'b1;
    step();
    i_err_clr = 1'b0;
    m_err = 3'b000;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_busy"}, o_busy, (m_phase != 0) || (exp_q.size() != 0));
    chk({tag, "_err"}, o_err, m_err);
  endtask

  // Scoreboard: every offered write must match the head of the expected queue
  always @(negedge i_sys_clk) begin
    if (i_rst_n && o_reg_wr_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write", o_reg_addr, o_reg_data);
      end else begin
        chk("write_payload", {o_reg_addr, o_reg_data}, exp_q[0]);
        if (i_reg_wr_ready) begin
          void'(exp_q.pop_front());
          n_accept++;
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge i_sys_clk);
    #1;
    chk("rst_addr", o_reg_addr, 0);
    chk("rst_data", o_reg_data, 0);
    chk("rst_valid", o_reg_wr_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err, 0);
    i_rst_n = 1'b1;
    step();

    // Basic write with ready held high
    n0 = n_accept;
    send_msg(8'h85, 8'h12, 8'h34);
    idle(6);
    check_idle("wr1");
    chk("wr1_accepts", n_accept - n0, 1);
    chk("wr1_addr", o_reg_addr, 7'h05);
    chk("wr1_data", o_reg_data, 16'h1234);
    chk("wr1_err", o_err, 3'b000);

    // Write held against backpressure
    i_reg_wr_ready = 1'b0;
    send_msg(8'h85, 8'h12, 8'h34);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", o_reg_wr_valid, 1);
      chk("hold_addr", o_reg_addr, 7'h05);
      chk("hold_data", o_reg_data, 16'h1234);
      step();
    end
    i_reg_wr_ready = 1'b1;
    step();
    chk("hold_clear", o_reg_wr_valid, 0);
    idle(2);
    check_idle("hold");

    // Inter-byte timeout, then recovery
    send_byte(8'h81);
    send_byte(8'hAB);
    idle(3 * TMO);
    check_idle("tmo");
    chk("tmo_err_lit", o_err, 3'b010);
    send_msg(8'h82, 8'h00, 8'h01);
    idle(6);
    check_idle("tmo_next");
    chk("tmo_next_addr", o_reg_addr, 7'h02);
    chk("tmo_next_data", o_reg_data, 16'h0001);

    // Misaligned frame mid-message
    err_clr();
    n0 = n_accept;
    send_byte(8'h85);
    send_byte(8'h12, 1'b0);
    idle(6);
    check_idle("mis");
    chk("mis_err_lit", o_err, 3'b001);
    chk("mis_no_write", n_accept - n0, 0);
    err_clr();
    chk("mis_cleared", o_err, 3'b000);

    // Overrun: second write arrives while the first is still pending
    i_reg_wr_ready = 1'b0;
    send_msg(8'h81, 8'hBE, 8'hEF);
    send_msg(8'h82, 8'h11, 8'h22);
    idle(3);
    chk("ovr_err_lit", o_err, 3'b100);
    chk("ovr_valid", o_reg_wr_valid, 1);
    chk("ovr_addr", o_reg_addr, 7'h01);
    chk("ovr_data", o_reg_data, 16'hBEEF);
    i_reg_wr_ready = 1'b1;
    idle(4);
    check_idle("ovr");

    // Read command is skipped silently, then a write still works
    err_clr();
    n0 = n_accept;
    send_msg(8'h03, 8'hFF, 8'hFF);
    idle(6);
    check_idle("rd");
    chk("rd_no_write", n_accept - n0, 0);
    send_msg(8'h84, 8'h56, 8'h78);
    idle(6);
    check_idle("rd_next");
    chk("rd_next_addr", o_reg_addr, 7'h04);
    chk("rd_next_data", o_reg_data, 16'h5678);

    // Reset in the middle of a message
    send_byte(8'h85);
    send_byte(8'hAA);
    i_rst_n = 1'b0;
    #1;
    m_phase = 0;
    m_err = 3'b000;
    exp_q.delete();
    chk("mrst_addr", o_reg_addr, 0);
    chk("mrst_data", o_reg_data, 0);
    chk("mrst_valid", o_reg_wr_valid, 0);
    chk("mrst_busy", o_busy, 0);
    chk("mrst_err", o_err, 0);
    step();
    step();
    i_rst_n = 1'b1;
    step();
    send_msg(8'h86, 8'hCD, 8'hEF);
    idle(6);
    check_idle("mrst_next");
    chk("mrst_next_addr", o_reg_addr, 7'h06);
    chk("mrst_next_data", o_reg_data, 16'hCDEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
